// File: rtl/op_pkg.sv
// Shared definitions for the matrix-controller command sequencer: opcodes,
// command/size field positions, FSM state encoding and size decode helpers.
package op_pkg;

    localparam logic [3:0] OP_IDLE = 4'd0;
    localparam logic [3:0] OP_MUL  = 4'd1;
    localparam logic [3:0] OP_WR   = 4'd2;
    localparam logic [3:0] OP_RD   = 4'd3;

    localparam int OPCODE_MSB     = 3;
    localparam int OPCODE_LSB     = 0;
    localparam int SIZE_LINES_MSB = 8;
    localparam int SIZE_LINES_LSB = 6;
    localparam int SIZE_CELLS_MSB = 5;
    localparam int SIZE_CELLS_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_MUL,
        ST_DRAIN,
        ST_SWR,
        ST_SRD,
        ST_GAP
    } state_t;

    function automatic logic [3:0] op_opcode(input logic [31:0] op);
        return op[OPCODE_MSB:OPCODE_LSB];
    endfunction

    // Size fields hold count-minus-one, so both decodes add one back.
    function automatic logic [15:0] size_lines(input logic [8:0] size);
        return {13'd0, size[SIZE_LINES_MSB:SIZE_LINES_LSB]} + 16'd1;
    endfunction

    function automatic logic [15:0] size_cells(input logic [8:0] size);
        return {10'd0, size[SIZE_CELLS_MSB:SIZE_CELLS_LSB]} + 16'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; head is shown combinationally.
// A pop frees the slot that a same-cycle push may use, even when full.
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/op_sequencer.sv
// Command front-end for the matrix controller: pops queued operation words, holds each
// op on the controller pins for its required duration and streams serial write/read data.
module op_sequencer
    import op_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int DRAIN_LAT = 24,
    parameter int RD_LAT    = 1,
    parameter int RD_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_op,
    input  logic [8:0]  cfg_size,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        ctl_enable,
    output logic [31:0] ctl_operation,
    output logic [31:0] ctl_in_data,
    output logic [8:0]  ctl_size,
    input  logic [31:0] ctl_out_data,
    output logic        busy,
    output logic        done
);

    state_t state;
    state_t next_state;

    logic [31:0] op_q;
    logic [8:0]  size_q;
    logic [15:0] cnt;
    logic [15:0] issued;
    logic [15:0] pushed;
    logic [15:0] n_ser;
    logic [15:0] n_mul;
    logic [15:0] in_flight;
    logic [15:0] rd_used;
    logic        issue;

    logic [31:0]                   cmd_head;
    logic [$clog2(CMD_DEPTH):0]    cmd_count;
    logic                          cmd_empty;
    logic                          cmd_full;
    logic                          cmd_pop;

    logic [RD_LAT-1:0]             rd_pipe;
    logic [31:0]                   rd_head;
    logic [$clog2(RD_DEPTH):0]     rd_count;
    logic                          rd_push;
    logic                          rd_pop;

    assign cmd_empty = (cmd_count == '0);
    assign cmd_full  = (cmd_count == ($clog2(CMD_DEPTH)+1)'(CMD_DEPTH));
    assign cmd_ready = !cmd_full;
    assign cmd_pop   = (state == ST_LAUNCH);

    sync_fifo #(.W(32), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (cmd_valid && cmd_ready),
        .push_data (cmd_op),
        .pop       (cmd_pop),
        .head      (cmd_head),
        .count     (cmd_count)
    );

    // Read data lands RD_LAT cycles after its issuing cycle; those in flight hold credit.
    assign rd_push   = rd_pipe[RD_LAT-1];
    assign rd_valid  = (rd_count != '0);
    assign rd_pop    = rd_valid && rd_ready;
    assign rd_data   = rd_valid ? rd_head : 32'd0;
    assign in_flight = 16'($countones(rd_pipe));
    assign rd_used   = in_flight + 16'(rd_count);

    sync_fifo #(.W(32), .DEPTH(RD_DEPTH)) u_rd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_push),
        .push_data (ctl_out_data),
        .pop       (rd_pop),
        .head      (rd_head),
        .count     (rd_count)
    );

    assign n_ser         = size_cells(size_q) * size_lines(size_q);
    assign n_mul         = n_ser * size_lines(size_q);
    assign ctl_operation = op_q;
    assign ctl_size      = size_q;
    assign busy          = (state != ST_IDLE) || !cmd_empty;
    assign done          = (state == ST_GAP);

    always_comb begin
        next_state  = state;
        ctl_enable  = 1'b1;
        wr_ready    = 1'b0;
        ctl_in_data = 32'd0;
        issue       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!cmd_empty) next_state = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                case (op_opcode(cmd_head))
                    OP_MUL:  next_state = ST_MUL;
                    OP_WR:   next_state = ST_SWR;
                    OP_RD:   next_state = ST_SRD;
                    default: next_state = ST_GAP;
                endcase
            end
            ST_MUL: begin
                if (cnt == n_mul - 16'd1) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (cnt == 16'(DRAIN_LAT - 1)) next_state = ST_GAP;
            end
            ST_SWR: begin
                ctl_enable  = wr_valid;
                wr_ready    = wr_valid;
                ctl_in_data = wr_data;
                if (wr_valid && cnt == n_ser - 16'd1) next_state = ST_GAP;
            end
            ST_SRD: begin
                issue      = (issued < n_ser) && (rd_used < 16'(RD_DEPTH));
                ctl_enable = issue;
                if (rd_push && pushed == n_ser - 16'd1) next_state = ST_GAP;
            end
            ST_GAP: begin
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // cnt restarts on every state change; it times MUL/DRAIN and counts SWR words.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            op_q    <= 32'd0;
            size_q  <= 9'd0;
            cnt     <= 16'd0;
            issued  <= 16'd0;
            pushed  <= 16'd0;
            rd_pipe <= '0;
        end else begin
            state   <= next_state;
            rd_pipe <= (rd_pipe << 1) | RD_LAT'(issue);

            if (next_state == ST_GAP || next_state == ST_IDLE) op_q <= {28'd0, OP_IDLE};
            else if (state == ST_LAUNCH)                       op_q <= cmd_head;

            if (state == ST_LAUNCH) size_q <= cfg_size;

            if (state != next_state)
                cnt <= 16'd0;
            else if (state == ST_MUL || state == ST_DRAIN || (state == ST_SWR && wr_valid))
                cnt <= cnt + 16'd1;

            if (state == ST_LAUNCH) begin
                issued <= 16'd0;
                pushed <= 16'd0;
            end else begin
                if (issue)                       issued <= issued + 16'd1;
                if (rd_push && state == ST_SRD)  pushed <= pushed + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_op_sequencer.sv
// Scoreboard bench for op_sequencer: expected ops, write words and read words are
// queued when driven and compared as the sequencer presents them.
module tb_op_sequencer;

    localparam int DRAIN_LAT = 24;
    localparam int RD_DEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_op;
    logic [8:0]  cfg_size;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        ctl_enable;
    logic [31:0] ctl_operation;
    logic [31:0] ctl_in_data;
    logic [8:0]  ctl_size;
    logic [31:0] ctl_out_data = 32'd0;
    logic        busy;
    logic        done;

    op_sequencer #(
        .CMD_DEPTH (4),
        .DRAIN_LAT (DRAIN_LAT),
        .RD_LAT    (1),
        .RD_DEPTH  (RD_DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cfg_size      (cfg_size),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_data       (wr_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .ctl_enable    (ctl_enable),
        .ctl_operation (ctl_operation),
        .ctl_in_data   (ctl_in_data),
        .ctl_size      (ctl_size),
        .ctl_out_data  (ctl_out_data),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op;
        logic [8:0]  size;
        int          en;
        int          len;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_wr[$];
    logic [31:0] exp_rd[$];

    int checks    = 0;
    int failures  = 0;
    int done_seen = 0;
    int rd_issue  = 0;
    int rx_count  = 0;
    bit issue_now = 1'b0;
    bit in_op     = 1'b0;
    int en_cnt    = 0;
    int len_cnt   = 0;
    logic [31:0] cur_op;
    logic [8:0]  cur_size;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Queue a command; the scoreboard entry exists only if the FIFO took it.
    task automatic applyStimulus(input logic [31:0] op, input logic [8:0] size,
                                 input int en, input int len, output bit accepted);
        exp_t e;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cfg_size  = size;
        accepted  = cmd_ready;
        if (accepted) begin
            e.op = op; e.size = size; e.en = en; e.len = len;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitIdle(input int max_cycles);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (busy && n < max_cycles);
        checkOutput("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic waitOp(input logic [3:0] opc, input int max_cycles);
        int n = 0;
        while (ctl_operation[3:0] != opc && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("op_start_timeout", {28'd0, ctl_operation[3:0]}, {28'd0, opc});
    endtask

    // Controller read model: one-cycle read latency, data tagged with issue order.
    always @(posedge clk) begin
        if (issue_now) begin
            ctl_out_data <= 32'hA500_0000 + 32'(rd_issue);
            exp_rd.push_back(32'hA500_0000 + 32'(rd_issue));
            rd_issue++;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        issue_now = !reset && ctl_enable && (ctl_operation[3:0] == 4'd3);
        if (reset) begin
            in_op = 1'b0;
        end else begin
            if (done) done_seen++;
            if (rd_valid && rd_ready) begin
                if (exp_rd.size() == 0) checkOutput("rd_unexpected", 32'(exp_rd.size()), 32'd1);
                else checkOutput("rd_data", rd_data, exp_rd.pop_front());
                rx_count++;
            end
            if (!in_op && ctl_operation != 32'd0) begin
                in_op    = 1'b1;
                en_cnt   = 0;
                len_cnt  = 0;
                cur_op   = ctl_operation;
                cur_size = ctl_size;
            end
            if (in_op) begin
                if (ctl_operation != 32'd0) begin
                    len_cnt++;
                    if (ctl_enable) en_cnt++;
                    checkOutput("op_stable", ctl_operation, cur_op);
                    checkOutput("size_stable", {23'd0, ctl_size}, {23'd0, cur_size});
                    if (ctl_operation[3:0] == 4'd2) begin
                        checkOutput("swr_enable", {31'd0, ctl_enable}, {31'd0, wr_valid});
                        checkOutput("swr_ready", {31'd0, wr_ready}, {31'd0, wr_valid});
                        if (ctl_enable) begin
                            if (exp_wr.size() == 0) checkOutput("wr_unexpected", 32'(exp_wr.size()), 32'd1);
                            else checkOutput("ctl_in_data", ctl_in_data, exp_wr.pop_front());
                        end
                    end
                end else begin
                    in_op = 1'b0;
                    checkOutput("gap_done", {31'd0, done}, 32'd1);
                    checkOutput("gap_enable", {31'd0, ctl_enable}, 32'd1);
                    if (exp_q.size() == 0) begin
                        checkOutput("op_unexpected", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("op_word", cur_op, e.op);
                        checkOutput("op_size", {23'd0, cur_size}, {23'd0, e.size});
                        checkOutput("op_enabled_cycles", 32'(en_cnt), 32'(e.en));
                        if (e.len >= 0) checkOutput("op_length", 32'(len_cnt), 32'(e.len));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit acc;
        int n_acc;
        int n;
        int done_before;
        bit pattern [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] word;

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 32'd0; cfg_size = 9'd0;
        wr_valid = 1'b0; wr_data = 32'd0; rd_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        reset = 1'b0;

        $display("[TB] test 1: reset and idle");
        repeat (10) @(posedge clk); #1;
        checkOutput("rst_operation", ctl_operation, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("rst_enable", {31'd0, ctl_enable}, 32'd1);
        checkOutput("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
        checkOutput("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        checkOutput("rst_rd_data", rd_data, 32'd0);
        checkOutput("rst_in_data", ctl_in_data, 32'd0);
        checkOutput("rst_size", {23'd0, ctl_size}, 32'd0);
        checkOutput("rst_done_count", 32'(done_seen), 32'd0);

        $display("[TB] test 2: multiply L=2 C=4, size changed mid-op");
        applyStimulus(32'h0000_0051, 9'b001_000011, 16 + DRAIN_LAT, 16 + DRAIN_LAT, acc);
        waitOp(4'd1, 20);
        cfg_size = 9'h1FF;
        waitIdle(200);
        checkOutput("t2_done_count", 32'(done_seen), 32'd1);

        $display("[TB] test 3: serial write with stalls");
        cfg_size = 9'b000_000011;
        applyStimulus(32'h0000_0062, cfg_size, 4, -1, acc);
        waitOp(4'd2, 20);
        word = 32'd10;
        for (int i = 0; i < 6; i++) begin
            wr_valid = pattern[i];
            wr_data  = pattern[i] ? word : 32'hBAD0_0000 + 32'(i);
            if (pattern[i]) begin
                exp_wr.push_back(word);
                word = word + 32'd1;
            end
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        waitIdle(50);
        checkOutput("t3_words_left", 32'(exp_wr.size()), 32'd0);
        checkOutput("t3_done_count", 32'(done_seen), 32'd2);

        $display("[TB] test 4: serial read with host back-pressure");
        applyStimulus(32'h0000_0073, 9'b001_000011, 8, -1, acc);
        waitOp(4'd3, 20);
        repeat (20) @(posedge clk); #1;
        checkOutput("t4_issued_stalled", 32'(rd_issue), 32'(RD_DEPTH));
        checkOutput("t4_enable_stalled", {31'd0, ctl_enable}, 32'd0);
        checkOutput("t4_rd_valid", {31'd0, rd_valid}, 32'd1);
        rd_ready = 1'b1;
        n = 0;
        while (rx_count < 8 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("t4_rx_count", 32'(rx_count), 32'd8);
        waitIdle(50);
        repeat (2) @(posedge clk); #1;
        checkOutput("t4_rd_left", 32'(exp_rd.size()), 32'd0);
        checkOutput("t4_rd_valid_end", {31'd0, rd_valid}, 32'd0);
        checkOutput("t4_issued_total", 32'(rd_issue), 32'd8);
        rd_ready = 1'b0;

        $display("[TB] test 5: command FIFO fill");
        n_acc = 0;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus({24'd0, 4'(i), 4'd1}, 9'd0, 1 + DRAIN_LAT, 1 + DRAIN_LAT, acc);
            n_acc += int'(acc);
        end
        checkOutput("t5_full", {31'd0, cmd_ready}, 32'd0);
        applyStimulus(32'h0000_0061, 9'd0, 1 + DRAIN_LAT, 1 + DRAIN_LAT, acc);
        checkOutput("t5_dropped", {31'd0, acc}, 32'd0);
        checkOutput("t5_accepted", 32'(n_acc), 32'd5);
        waitIdle(1000);
        checkOutput("t5_done_count", 32'(done_seen), 32'd8);

        $display("[TB] test 6: reset during multiply");
        applyStimulus(32'h0000_0081, 9'b001_000011, 16 + DRAIN_LAT, 16 + DRAIN_LAT, acc);
        waitOp(4'd1, 20);
        repeat (5) @(posedge clk); #1;
        exp_q.delete();
        done_before = done_seen;
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("t6_operation", ctl_operation, 32'd0);
        checkOutput("t6_done", {31'd0, done}, 32'd0);
        checkOutput("t6_busy", {31'd0, busy}, 32'd0);
        checkOutput("t6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("t6_rd_valid", {31'd0, rd_valid}, 32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clk); #1;
        checkOutput("t6_no_done", 32'(done_seen), 32'(done_before));
        applyStimulus(32'h0000_0091, 9'b001_000011, 16 + DRAIN_LAT, 16 + DRAIN_LAT, acc);
        waitIdle(200);
        checkOutput("t6_done_after", 32'(done_seen), 32'(done_before + 1));
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
